// File: rtl/pe_pkg.sv
// Shared defaults and constants for the double-buffered systolic processing element.
// Build option: define PE_DBUF_SATURATE_EN for saturating MAC results (default wraps).
package pe_pkg;
    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_FRAC_BITS  = 8;

    typedef logic signed [PE_DATA_WIDTH-1:0] data_t;

    localparam data_t SAT_MAX = {1'b0, {(PE_DATA_WIDTH-1){1'b1}}};
    localparam data_t SAT_MIN = {1'b1, {(PE_DATA_WIDTH-1){1'b0}}};
endpackage

// File: rtl/pe_dbuf_fxp_mac.sv
// Combinational fixed-point MAC: result = ((a * b) >>> FRAC_BITS) + c, narrowed to DATA_WIDTH.
// PE_DBUF_SATURATE_EN selects clipping instead of wrapping; overflow is reported either way.
module fxp_mac
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = pe_pkg::PE_DATA_WIDTH,
    parameter int FRAC_BITS  = pe_pkg::PE_FRAC_BITS
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW:0]   sum;

    always_comb begin
        prod   = $signed(a) * $signed(b);
        scaled = prod >>> FRAC_BITS;
        sum    = {scaled[PW-1], scaled} + {{(DATA_WIDTH+1){c[DATA_WIDTH-1]}}, c};
        // In range only if every bit above the narrow sign bit matches it.
        overflow = !((&sum[PW:DATA_WIDTH-1]) || !(|sum[PW:DATA_WIDTH-1]));
`ifdef PE_DBUF_SATURATE_EN
        if (overflow) begin
            result = sum[PW] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            result = sum[DATA_WIDTH-1:0];
        end
`else
        result = sum[DATA_WIDTH-1:0];
`endif
    end
endmodule

// File: rtl/pe_dbuf.sv
// Systolic PE register stage: east activation, south psum, shadow/active weight pair, switch wave.
// Build option: PE_DBUF_SATURATE_EN (resolved inside fxp_mac) selects saturating arithmetic.
module pe_dbuf
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = pe_pkg::PE_DATA_WIDTH,
    parameter int FRAC_BITS  = pe_pkg::PE_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_in,
    input  logic                  input_valid_in,
    input  logic [DATA_WIDTH-1:0] psum_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_shift,
    input  logic                  switch_in,
    input  logic                  clear_ovf,
    output logic [DATA_WIDTH-1:0] input_out,
    output logic                  input_valid_out,
    output logic [DATA_WIDTH-1:0] psum_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  switch_out,
    output logic                  ovf
);
    logic [DATA_WIDTH-1:0] input_q, input_d;
    logic [DATA_WIDTH-1:0] psum_q, psum_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  valid_q, valid_d;
    logic                  switch_q, switch_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] mac_result;
    logic                  mac_ovf;

    fxp_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .a        (input_in),
        .b        (active_q),
        .c        (psum_in),
        .result   (mac_result),
        .overflow (mac_ovf)
    );

    always_comb begin
        input_d  = input_q;
        psum_d   = psum_q;
        valid_d  = input_valid_in;
        shadow_d = weight_shift ? weight_in : shadow_q;
        // Promotion reads the pre-edge shadow, so a shift on the same edge is not lost.
        active_d = switch_in ? shadow_q : active_q;
        switch_d = switch_in;
        ovf_d    = ovf_q;
        if (input_valid_in) begin
            input_d = input_in;
            psum_d  = mac_result;
        end
        if (clear_ovf) begin
            ovf_d = 1'b0;
        end
        if (input_valid_in && mac_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_q  <= '0;
            psum_q   <= '0;
            shadow_q <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            input_q  <= input_d;
            psum_q   <= psum_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
            ovf_q    <= ovf_d;
        end
    end

    assign input_out       = input_q;
    assign input_valid_out = valid_q;
    assign psum_out        = psum_q;
    assign weight_out      = shadow_q;
    assign switch_out      = switch_q;
    assign ovf             = ovf_q;
endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
Parametrised fixed-point systolic processing element with double-buffered weights.
- Inputs flow east, partial sums flow south, weights daisy-chain south through a shadow register.
- A diagonal switch wave promotes shadow weights to active weights, so the next weight tile preloads while the current tile computes.
- Used as the cell of the parametrised systolic array; one instance per array position.

Parameters:
DATA_WIDTH, 16, width of input, weight and psum words (signed two's complement)
FRAC_BITS, 8, fractional bits of the fixed-point format; must satisfy 0 <= FRAC_BITS < DATA_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
input_in  in  DATA_WIDTH  activation from west neighbour
input_valid_in  in  1  input_in/psum_in qualify a MAC this cycle
psum_in  in  DATA_WIDTH  partial sum from north neighbour
weight_in  in  DATA_WIDTH  weight from north neighbour's shadow chain
weight_shift  in  1  shift weight chain: shadow <= weight_in
switch_in  in  1  promote shadow weight to active weight
clear_ovf  in  1  clear sticky overflow flag
input_out  out  DATA_WIDTH  registered activation to east neighbour
input_valid_out  out  1  registered valid to east/south neighbours
psum_out  out  DATA_WIDTH  registered MAC result to south neighbour
weight_out  out  DATA_WIDTH  shadow weight register, to south neighbour's weight_in
switch_out  out  1  switch_in delayed one cycle, to east neighbour
ovf  out  1  sticky arithmetic overflow flag

Behaviour:
- Reset (rst_n low, asynchronous): input_out, psum_out, weight_out (shadow), active weight, input_valid_out, switch_out and ovf all clear to 0. Reset mid-operation discards all state immediately; no partial result survives.
- MAC, combinational inside the cell:
  - prod = input_in * active_weight, full 2*DATA_WIDTH signed.
  - scaled = prod >>> FRAC_BITS (arithmetic shift; truncation toward -inf).
  - sum = scaled + sign-extended psum_in, kept wide enough to be exact.
  - Result narrowed to DATA_WIDTH per Optional Feature.
- Valid path, latency 1 cycle:
  - input_valid_in=1: next edge loads input_out<=input_in, psum_out<=result, input_valid_out<=1.
  - input_valid_in=0: input_valid_out<=0; input_out and psum_out hold their previous values.
- Weight chain:
  - weight_shift=1: weight_out<=weight_in on the edge. A column of N cells loads in N shift cycles, bottom row first.
- Switch:
  - switch_in=1: active<=weight_out (pre-edge shadow value).
  - switch_out<=switch_in every cycle (1-cycle diagonal propagation, independent of valid).
  - A MAC in the same cycle as switch_in uses the OLD active weight. The first MAC with the new weight is the next cycle.
- Simultaneous weight_shift and switch_in: active takes the old shadow value and shadow takes weight_in; both happen on the same edge with no loss.
- Overflow:
  - ovf sets on any valid MAC whose exact sum falls outside the DATA_WIDTH signed range. It stays set until clear_ovf.
  - clear_ovf and a new overflow in the same cycle: ovf=1 (set wins).
  - Invalid cycles never set ovf.

Optional Feature:
Macro PE_DBUF_SATURATE_EN.
- Defined: out-of-range sums clip to the signed max (0111..1) or signed min (1000..0).
- Undefined: sums wrap (keep the low DATA_WIDTH bits).
- ovf behaves identically in both builds.

Decomposition:
- Package pe_pkg: DATA_WIDTH/FRAC_BITS defaults, the data_t typedef, and SAT_MAX/SAT_MIN constants.
- One combinational sub-module, fxp_mac: ports a, b, c, result, overflow. It holds the multiply, shift, add and narrowing; the macro is resolved inside it.
- pe_dbuf holds the registers only.

Test Plan:
- Reset: drive rst_n low mid-stream with input_valid_in=1 -> all outputs 0 asynchronously, before the next clk edge; after release, the first valid MAC uses active weight 0 -> psum_out=psum_in.
- Basic MAC (DATA_WIDTH=16, FRAC_BITS=8): shift in 0x0180, pulse switch_in, then input_in=0x0200, psum_in=0x0100, valid -> one cycle later psum_out=0x0400, input_out=0x0200, input_valid_out=1, ovf=0.
- Double buffer: while the active weight is 0x0100, shift in 0x0300 and keep streaming input_in=0x0100, psum_in=0 -> psum_out stays 0x0100. Pulse switch_in with a valid MAC in the same cycle -> that cycle gives 0x0100, next cycle gives 0x0300; switch_out pulses exactly one cycle after switch_in.
- Overflow: active weight 0x0200, input_in=0x7FFF, psum_in=0:
  - macro defined -> psum_out=0x7FFF, ovf=1;
  - macro undefined -> psum_out=0xFFFE, ovf=1;
  - input_in=0x8000 with macro defined -> psum_out=0x8000.
  - clear_ovf plus a non-overflowing MAC -> ovf=0; clear_ovf plus an overflowing MAC -> ovf stays 1.
- Bubble and chain: input_valid_in low for 3 cycles -> input_valid_out low, data held, ovf unchanged. weight_shift with switch_in on the same edge, shadow=0x0100, weight_in=0x0500 -> active=0x0100, weight_out=0x0500.
